// File: rtl/basilisc_2816_cpu.sv
`default_nettype none
// ============================================================================
// Module   : basilisc_2816_cpu
// Brief    : 8-bit CPU tile talking to an external memory agent over pins.
// Revision : 1.0
// ============================================================================
module basilisc_2816_cpu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [1:0] c_req_idle  = 2'd0;
    localparam logic [1:0] c_req_read  = 2'd1;
    localparam logic [1:0] c_req_waddr = 2'd2;
    localparam logic [1:0] c_req_wdata = 2'd3;

    localparam logic [1:0] c_tag_op   = 2'd1;
    localparam logic [1:0] c_tag_arg  = 2'd2;
    localparam logic [1:0] c_tag_data = 2'd3;

    localparam logic [3:0] c_op_mov  = 4'd0;
    localparam logic [3:0] c_op_add  = 4'd1;
    localparam logic [3:0] c_op_adc  = 4'd2;
    localparam logic [3:0] c_op_sub  = 4'd3;
    localparam logic [3:0] c_op_sbc  = 4'd4;
    localparam logic [3:0] c_op_and  = 4'd5;
    localparam logic [3:0] c_op_or   = 4'd6;
    localparam logic [3:0] c_op_xor  = 4'd7;
    localparam logic [3:0] c_op_cmp  = 4'd8;
    localparam logic [3:0] c_op_ld   = 4'd9;
    localparam logic [3:0] c_op_st   = 4'd10;
    localparam logic [3:0] c_op_push = 4'd11;
    localparam logic [3:0] c_op_pop  = 4'd12;
    localparam logic [3:0] c_op_call = 4'd13;
    localparam logic [3:0] c_op_ret  = 4'd14;
    localparam logic [3:0] c_op_jcc  = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH0 = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WDATA  = 3'd5
    } state_t;

    state_t     r_state, w_state_nxt;

    logic [7:0] r_pc, w_pc_nxt;
    logic [7:0] r_sp, w_sp_nxt;
    logic [7:0] r_regs [8];
    logic [7:0] w_regs_nxt [8];
    logic       r_flag_z, r_flag_s, r_flag_c, r_flag_v;
    logic       w_flag_z_nxt, w_flag_s_nxt, w_flag_c_nxt, w_flag_v_nxt;
    logic [7:0] r_b0, w_b0_nxt;
    logic [7:0] r_b1, w_b1_nxt;
    logic       r_have_b0, w_have_b0_nxt;
    logic       r_have_b1, w_have_b1_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic [7:0] r_uo_out;
    logic [1:0] r_req_type;
    logic [1:0] w_req_type;
    logic [7:0] w_req_data;

    // Outstanding-read tag FIFO
    logic [1:0] r_fifo_entries [4];
    logic [1:0] r_fifo_head;
    logic [2:0] r_fifo_count;
    logic [1:0] w_fifo_tail;
    logic [1:0] w_head_tag;
    logic       w_fifo_full;
    logic       w_push;
    logic [1:0] w_push_tag;
    logic       w_pop;
    logic       w_rx_valid;

    assign w_rx_valid  = uio_in[2];
    assign w_fifo_full = (r_fifo_count == 3'd4);
    assign w_pop       = w_rx_valid && (r_fifo_count != 3'd0);
    assign w_head_tag  = r_fifo_entries[r_fifo_head];
    assign w_fifo_tail = r_fifo_head + r_fifo_count[1:0];

    // Instruction decode
    logic [3:0] w_op;
    logic       w_imm;
    logic [2:0] w_rd;
    logic [3:0] w_cc;
    logic [7:0] w_dst;
    logic [7:0] w_ptr;
    logic [7:0] w_src;
    logic       w_is_read_op;

    assign w_op         = r_b0[7:4];
    assign w_imm        = r_b0[3];
    assign w_rd         = r_b0[2:0];
    assign w_cc         = r_b0[3:0];
    assign w_dst        = r_regs[w_rd];
    assign w_ptr        = r_regs[r_b1[2:0]];
    assign w_src        = w_imm ? r_b1 : w_ptr;
    assign w_is_read_op = (w_op == c_op_ld) || (w_op == c_op_pop) || (w_op == c_op_ret);

    // ALU
    logic       w_cin;
    logic [8:0] w_add9, w_sub9;
    logic [7:0] w_alu_res;
    logic       w_alu_c, w_alu_v, w_alu_flags, w_alu_wb;

    assign w_cin  = ((w_op == c_op_adc) || (w_op == c_op_sbc)) ? r_flag_c : 1'b0;
    assign w_add9 = {1'b0, w_dst} + {1'b0, w_src} + {8'd0, w_cin};
    assign w_sub9 = {1'b0, w_dst} - {1'b0, w_src} - {8'd0, w_cin};

    always_comb begin
        w_alu_res   = w_src;
        w_alu_c     = r_flag_c;
        w_alu_v     = r_flag_v;
        w_alu_flags = 1'b0;
        w_alu_wb    = 1'b1;
        case (w_op)
            c_op_mov: w_alu_res = w_src;
            c_op_add, c_op_adc: begin
                w_alu_res   = w_add9[7:0];
                w_alu_c     = w_add9[8];
                w_alu_v     = (w_dst[7] == w_src[7]) && (w_add9[7] != w_dst[7]);
                w_alu_flags = 1'b1;
            end
            c_op_sub, c_op_sbc, c_op_cmp: begin
                // Bit 8 of the 9-bit difference is the borrow
                w_alu_res   = w_sub9[7:0];
                w_alu_c     = w_sub9[8];
                w_alu_v     = (w_dst[7] != w_src[7]) && (w_sub9[7] != w_dst[7]);
                w_alu_flags = 1'b1;
                w_alu_wb    = (w_op != c_op_cmp);
            end
            c_op_and, c_op_or, c_op_xor: begin
                w_alu_res   = (w_op == c_op_and) ? (w_dst & w_src) :
                              (w_op == c_op_or)  ? (w_dst | w_src) : (w_dst ^ w_src);
                w_alu_c     = 1'b0;
                w_alu_v     = 1'b0;
                w_alu_flags = 1'b1;
            end
            default: w_alu_wb = 1'b0;
        endcase
    end

    // Condition evaluation: cc[3:1] selects the test, cc[0] inverts it
    logic w_cond_base, w_cond;

    always_comb begin
        w_cond_base = 1'b1;
        case (w_cc[3:1])
            3'd0: w_cond_base = 1'b1;
            3'd1: w_cond_base = r_flag_z;
            3'd2: w_cond_base = r_flag_s;
            3'd3: w_cond_base = r_flag_c;
            3'd4: w_cond_base = !r_flag_c && !r_flag_z;
            3'd5: w_cond_base = r_flag_v;
            3'd6: w_cond_base = !r_flag_z && (r_flag_s == r_flag_v);
            3'd7: w_cond_base = (r_flag_s == r_flag_v);
        endcase
    end

    assign w_cond = w_cond_base ^ w_cc[0];

    // Next-state and datapath
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_sp_nxt      = r_sp;
        w_regs_nxt    = r_regs;
        w_flag_z_nxt  = r_flag_z;
        w_flag_s_nxt  = r_flag_s;
        w_flag_c_nxt  = r_flag_c;
        w_flag_v_nxt  = r_flag_v;
        w_b0_nxt      = r_b0;
        w_b1_nxt      = r_b1;
        w_have_b0_nxt = r_have_b0;
        w_have_b1_nxt = r_have_b1;
        w_wdata_nxt   = r_wdata;
        w_req_type    = c_req_idle;
        w_req_data    = 8'd0;
        w_push        = 1'b0;
        w_push_tag    = 2'd0;

        if (w_pop) begin
            case (w_head_tag)
                c_tag_op: begin
                    w_b0_nxt      = ui_in;
                    w_have_b0_nxt = 1'b1;
                end
                c_tag_arg: begin
                    w_b1_nxt      = ui_in;
                    w_have_b1_nxt = 1'b1;
                end
                default: ;
            endcase
        end

        case (r_state)
            ST_FETCH0: begin
                if (!w_fifo_full) begin
                    w_req_type  = c_req_read;
                    w_req_data  = r_pc;
                    w_push      = 1'b1;
                    w_push_tag  = c_tag_op;
                    w_state_nxt = ST_FETCH1;
                end
            end
            ST_FETCH1: begin
                if (!w_fifo_full) begin
                    w_req_type  = c_req_read;
                    w_req_data  = r_pc + 8'd1;
                    w_push      = 1'b1;
                    w_push_tag  = c_tag_arg;
                    w_pc_nxt    = r_pc + 8'd2;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_have_b0 && r_have_b1) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!(w_is_read_op && w_fifo_full)) begin
                    w_have_b0_nxt = 1'b0;
                    w_have_b1_nxt = 1'b0;
                    w_state_nxt   = ST_FETCH0;
                    case (w_op)
                        c_op_ld: begin
                            w_req_type  = c_req_read;
                            w_req_data  = w_ptr;
                            w_push      = 1'b1;
                            w_push_tag  = c_tag_data;
                            w_state_nxt = ST_MEM;
                        end
                        c_op_pop, c_op_ret: begin
                            w_req_type  = c_req_read;
                            w_req_data  = r_sp;
                            w_push      = 1'b1;
                            w_push_tag  = c_tag_data;
                            w_state_nxt = ST_MEM;
                        end
                        c_op_st: begin
                            w_req_type  = c_req_waddr;
                            w_req_data  = w_ptr;
                            w_wdata_nxt = w_dst;
                            w_state_nxt = ST_WDATA;
                        end
                        c_op_push, c_op_call: begin
                            // CALL pushes the already-advanced PC as return address
                            w_sp_nxt    = r_sp - 8'd1;
                            w_req_type  = c_req_waddr;
                            w_req_data  = r_sp - 8'd1;
                            w_wdata_nxt = (w_op == c_op_call) ? r_pc : w_dst;
                            if (w_op == c_op_call) begin
                                w_pc_nxt = r_b1;
                            end
                            w_state_nxt = ST_WDATA;
                        end
                        c_op_jcc: begin
                            if (w_cond) begin
                                w_pc_nxt = r_b1;
                            end
                        end
                        default: begin
                            if (w_alu_wb) begin
                                w_regs_nxt[w_rd] = w_alu_res;
                            end
                            if (w_alu_flags) begin
                                w_flag_z_nxt = (w_alu_res == 8'd0);
                                w_flag_s_nxt = w_alu_res[7];
                                w_flag_c_nxt = w_alu_c;
                                w_flag_v_nxt = w_alu_v;
                            end
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (w_pop && (w_head_tag == c_tag_data)) begin
                    case (w_op)
                        c_op_ld: w_regs_nxt[w_rd] = ui_in;
                        c_op_pop: begin
                            w_regs_nxt[w_rd] = ui_in;
                            w_sp_nxt         = r_sp + 8'd1;
                        end
                        c_op_ret: begin
                            w_pc_nxt = ui_in;
                            w_sp_nxt = r_sp + 8'd1;
                        end
                        default: ;
                    endcase
                    w_state_nxt = ST_FETCH0;
                end
            end
            ST_WDATA: begin
                w_req_type  = c_req_wdata;
                w_req_data  = r_wdata;
                w_state_nxt = ST_FETCH0;
            end
            default: w_state_nxt = ST_FETCH0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= 8'd0;
            r_sp           <= 8'd0;
            r_regs         <= '{default: 8'd0};
            r_flag_z       <= 1'b0;
            r_flag_s       <= 1'b0;
            r_flag_c       <= 1'b0;
            r_flag_v       <= 1'b0;
            r_b0           <= 8'd0;
            r_b1           <= 8'd0;
            r_have_b0      <= 1'b0;
            r_have_b1      <= 1'b0;
            r_wdata        <= 8'd0;
            r_uo_out       <= 8'd0;
            r_req_type     <= c_req_idle;
            r_fifo_entries <= '{default: 2'd0};
            r_fifo_head    <= 2'd0;
            r_fifo_count   <= 3'd0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_sp       <= w_sp_nxt;
            r_regs     <= w_regs_nxt;
            r_flag_z   <= w_flag_z_nxt;
            r_flag_s   <= w_flag_s_nxt;
            r_flag_c   <= w_flag_c_nxt;
            r_flag_v   <= w_flag_v_nxt;
            r_b0       <= w_b0_nxt;
            r_b1       <= w_b1_nxt;
            r_have_b0  <= w_have_b0_nxt;
            r_have_b1  <= w_have_b1_nxt;
            r_wdata    <= w_wdata_nxt;
            r_uo_out   <= w_req_data;
            r_req_type <= w_req_type;
            if (w_push) begin
                r_fifo_entries[w_fifo_tail] <= w_push_tag;
            end
            r_fifo_head  <= r_fifo_head + {1'b0, w_pop};
            r_fifo_count <= r_fifo_count + {2'd0, w_push} - {2'd0, w_pop};
        end
    end

    assign uo_out  = r_uo_out;
    assign uio_out = {6'd0, r_req_type};
    assign uio_oe  = 8'h03;

    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in[7:3], uio_in[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_basilisc_2816_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_basilisc_2816_cpu
// Brief    : Memory agent plus instruction-level reference model for the CPU.
// Revision : 1.0
// ============================================================================
module tb_basilisc_2816_cpu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    basilisc_2816_cpu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus-side memory (what the DUT's requests actually did)
    logic [7:0] d_mem [256];
    // Architectural reference model
    int m_mem [256];
    int m_r [8];
    int m_pc, m_sp, m_z, m_s, m_c, m_v;

    int exp_q [$];
    int pend_addr [$];
    int pend_cyc [$];
    int read_log [$];
    int waddr_log [$];
    int wdata_log [$];
    int waddr_cyc [$];
    int wdata_cyc [$];
    int cyc = 0;
    int idle = 0;
    int wa_addr = 0;
    bit run_active = 1'b0;

    function automatic int cond_true(input int cc);
        case (cc)
            0:  return 1;
            1:  return 0;
            2:  return m_z;
            3:  return (m_z == 0) ? 1 : 0;
            4:  return m_s;
            5:  return (m_s == 0) ? 1 : 0;
            6:  return m_c;
            7:  return (m_c == 0) ? 1 : 0;
            8:  return (m_c == 0 && m_z == 0) ? 1 : 0;
            9:  return (m_c == 1 || m_z == 1) ? 1 : 0;
            10: return m_v;
            11: return (m_v == 0) ? 1 : 0;
            12: return (m_z == 0 && m_s == m_v) ? 1 : 0;
            13: return (m_z == 1 || m_s != m_v) ? 1 : 0;
            14: return (m_s == m_v) ? 1 : 0;
            default: return (m_s != m_v) ? 1 : 0;
        endcase
    endfunction

    // Executes one whole instruction and queues the bus requests it implies
    task automatic model_step();
        int b0, b1, op, rd, src, a, res, t, addr, cin;
        b0 = m_mem[m_pc];
        b1 = m_mem[(m_pc + 1) % 256];
        exp_q.push_back(256 + m_pc);
        exp_q.push_back(256 + (m_pc + 1) % 256);
        m_pc = (m_pc + 2) % 256;
        op   = b0 / 16;
        rd   = b0 % 8;
        src  = ((b0 / 8) % 2 == 1) ? b1 : m_r[b1 % 8];
        a    = m_r[rd];
        case (op)
            0: m_r[rd] = src;
            1, 2, 3, 4, 8: begin
                cin = (op == 2 || op == 4) ? m_c : 0;
                if (op == 1 || op == 2) begin
                    t   = a + src + cin;
                    res = t % 256;
                    m_c = (t > 255) ? 1 : 0;
                    m_v = ((a >= 128) == (src >= 128) && (res >= 128) != (a >= 128)) ? 1 : 0;
                end else begin
                    t   = a - src - cin;
                    res = (t + 256) % 256;
                    m_c = (t < 0) ? 1 : 0;
                    m_v = ((a >= 128) != (src >= 128) && (res >= 128) != (a >= 128)) ? 1 : 0;
                end
                m_z = (res == 0) ? 1 : 0;
                m_s = (res >= 128) ? 1 : 0;
                if (op != 8) m_r[rd] = res;
            end
            5, 6, 7: begin
                res = (op == 5) ? (a & src) : (op == 6) ? (a | src) : (a ^ src);
                m_z = (res == 0) ? 1 : 0;
                m_s = (res >= 128) ? 1 : 0;
                m_c = 0;
                m_v = 0;
                m_r[rd] = res;
            end
            9: begin
                addr = m_r[b1 % 8];
                exp_q.push_back(256 + addr);
                m_r[rd] = m_mem[addr];
            end
            10: begin
                addr = m_r[b1 % 8];
                exp_q.push_back(512 + addr);
                exp_q.push_back(768 + a);
                m_mem[addr] = a;
            end
            11: begin
                m_sp = (m_sp + 255) % 256;
                exp_q.push_back(512 + m_sp);
                exp_q.push_back(768 + a);
                m_mem[m_sp] = a;
            end
            12: begin
                exp_q.push_back(256 + m_sp);
                m_r[rd] = m_mem[m_sp];
                m_sp = (m_sp + 1) % 256;
            end
            13: begin
                m_sp = (m_sp + 255) % 256;
                exp_q.push_back(512 + m_sp);
                exp_q.push_back(768 + m_pc);
                m_mem[m_sp] = m_pc;
                m_pc = b1;
            end
            14: begin
                exp_q.push_back(256 + m_sp);
                m_pc = m_mem[m_sp];
                m_sp = (m_sp + 1) % 256;
            end
            default: if (cond_true(b0 % 16) == 1) m_pc = b1;
        endcase
    endtask

    // Memory agent: checks each request, answers reads in order with random delay
    always @(negedge clk) begin : p_agent
        int e, obs, t;
        cyc++;
        if (run_active && rst_n) begin
            t = int'(uio_out[1:0]);
            if (t != 0) begin
                idle = 0;
                if (exp_q.size() == 0) model_step();
                e   = exp_q.pop_front();
                obs = int'(uio_out) * 256 + int'(uo_out);
                check_value("bus_request", obs, e);
                case (t)
                    1: begin
                        pend_addr.push_back(int'(uo_out));
                        pend_cyc.push_back(cyc);
                        read_log.push_back(int'(uo_out));
                    end
                    2: begin
                        wa_addr = int'(uo_out);
                        waddr_log.push_back(int'(uo_out));
                        waddr_cyc.push_back(cyc);
                    end
                    default: begin
                        d_mem[wa_addr] = uo_out;
                        wdata_log.push_back(int'(uo_out));
                        wdata_cyc.push_back(cyc);
                    end
                endcase
            end else begin
                idle++;
                if (idle > 64) begin
                    check_value("bus_timeout", idle, 0);
                    idle = 0;
                end
            end
            if (pend_addr.size() > 0 && pend_cyc[0] < cyc && $urandom_range(0, 1) == 1) begin
                void'(pend_cyc.pop_front());
                ui_in  = d_mem[pend_addr.pop_front()];
                uio_in = 8'($urandom_range(0, 255)) | 8'h04;
            end else if (pend_addr.size() == 0 && $urandom_range(0, 3) == 0) begin
                // Stray response with nothing outstanding
                ui_in  = 8'($urandom_range(0, 255));
                uio_in = 8'($urandom_range(0, 255)) | 8'h04;
            end else begin
                ui_in  = 8'($urandom_range(0, 255));
                uio_in = 8'($urandom_range(0, 255)) & 8'hFB;
            end
        end
    end

    task automatic start_run();
        #3;
        rst_n      = 1'b0;
        run_active = 1'b0;
        uio_in     = 8'hFF;
        ui_in      = 8'h3C;
        #1;
        check_value("rst_uo_out", uo_out, 0);
        check_value("rst_uio_out", uio_out, 0);
        repeat (2) @(negedge clk);
        check_value("rst_fifo_count", dut.r_fifo_count, 0);
        check_value("rst_pc_sp", {dut.r_pc, dut.r_sp}, 0);
        for (int i = 0; i < 256; i++) m_mem[i] = int'(d_mem[i]);
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_pc = 0; m_sp = 0; m_z = 0; m_s = 0; m_c = 0; m_v = 0;
        exp_q.delete(); pend_addr.delete(); pend_cyc.delete(); read_log.delete();
        waddr_log.delete(); wdata_log.delete(); waddr_cyc.delete(); wdata_cyc.delete();
        idle = 0;
        #2;
        rst_n      = 1'b1;
        uio_in     = 8'h04;
        ui_in      = 8'hF0;
        run_active = 1'b1;
    endtask

    task automatic run_directed(input int cycles);
        start_run();
        repeat (cycles) @(negedge clk);
        #1;
        run_active = 1'b0;
        uio_in     = 8'h00;
    endtask

    task automatic load_prog(input int addr, input int b0, input int b1);
        d_mem[addr % 256]       = 8'(b0);
        d_mem[(addr + 1) % 256] = 8'(b1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) d_mem[i] = 8'h00;
    endtask

    int cc_list [6]    = '{6, 15, 9, 8, 14, 12};
    int cc_taken [6]   = '{1, 1, 1, 0, 0, 0};

    initial begin
        check_value("uio_oe", uio_oe, 8'h03);

        // MOV r0,#5
        clear_mem();
        load_prog(0, 8'h08, 8'h05);
        load_prog(2, 8'hF0, 8'h02);
        run_directed(100);
        check_value("mov_read0", read_log[0], 8'h00);
        check_value("mov_read1", read_log[1], 8'h01);
        check_value("mov_next_read", read_log[2], 8'h02);
        check_value("mov_r0", dut.r_regs[0], 8'h05);

        // MOV, ADD r0,#FB, JZ 20 / JNZ 20
        for (int v = 0; v < 2; v++) begin
            clear_mem();
            load_prog(0, 8'h08, 8'h05);
            load_prog(2, 8'h18, 8'hFB);
            load_prog(4, (v == 0) ? 8'hF2 : 8'hF3, 8'h20);
            load_prog(6, 8'hF0, 8'h06);
            load_prog(8'h20, 8'hF0, 8'h20);
            run_directed(120);
            check_value("add_r0", dut.r_regs[0], 8'h00);
            check_value("add_flags_zscv", {dut.r_flag_z, dut.r_flag_s, dut.r_flag_c, dut.r_flag_v}, 4'b1010);
            check_value((v == 0) ? "jz_target" : "jnz_fallthrough", read_log[6], (v == 0) ? 8'h20 : 8'h06);
        end

        // ST r1,[r2]
        clear_mem();
        load_prog(0, 8'h09, 8'hAA);
        load_prog(2, 8'h0A, 8'h40);
        load_prog(4, 8'hA1, 8'h02);
        load_prog(6, 8'hF0, 8'h06);
        run_directed(120);
        check_value("st_waddr", waddr_log[0], 8'h40);
        check_value("st_wdata", wdata_log[0], 8'hAA);
        check_value("st_wdata_next_cycle", wdata_cyc[0] - waddr_cyc[0], 1);
        check_value("st_mem", d_mem[8'h40], 8'hAA);

        // PUSH r3 / POP r4
        clear_mem();
        load_prog(0, 8'h0B, 8'h5A);
        load_prog(2, 8'hB3, 8'h00);
        load_prog(4, 8'hC4, 8'h00);
        load_prog(6, 8'hF0, 8'h06);
        run_directed(120);
        check_value("push_waddr", waddr_log[0], 8'hFF);
        check_value("push_wdata", wdata_log[0], 8'h5A);
        check_value("pop_r4", dut.r_regs[4], 8'h5A);
        check_value("pop_sp", dut.r_sp, 8'h00);

        // CMP r0=01 with #02, then one conditional jump each
        for (int k = 0; k < 6; k++) begin
            clear_mem();
            load_prog(0, 8'h08, 8'h01);
            load_prog(2, 8'h88, 8'h02);
            load_prog(4, 8'hF0 + cc_list[k], 8'h20);
            load_prog(6, 8'hF0, 8'h06);
            load_prog(8'h20, 8'hF0, 8'h20);
            run_directed(120);
            if (k == 0) begin
                check_value("cmp_flags_zsc", {dut.r_flag_z, dut.r_flag_s, dut.r_flag_c}, 3'b011);
                check_value("cmp_r0_kept", dut.r_regs[0], 8'h01);
            end
            check_value($sformatf("jcc_%0d", cc_list[k]), read_log[6], (cc_taken[k] == 1) ? 8'h20 : 8'h06);
        end

        // Random programs; each new segment resets mid-instruction
        for (int seg = 0; seg < 4; seg++) begin
            if (seg % 2 == 0) begin
                for (int i = 0; i < 256; i++) d_mem[i] = 8'($urandom_range(0, 255));
            end
            start_run();
            repeat (2500) @(negedge clk);
        end
        #1;
        run_active = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/basilisc_2816_cpu.md
# basilisc_2816_cpu

Top-level TinyTapeout tile (`tt_um_toivoh_basilisc_2816_cpu_OL2`) containing a small 8-bit CPU. The CPU has eight 8-bit general registers, an 8-bit SP, an 8-bit PC and x86-style ZSCV flags. It talks to an external memory agent over a request/response pin protocol. Outstanding reads are tracked in a 4-entry, 2-bit message-type FIFO (`cpu.fifo.entries[]`). Registers live in `cpu.dec.sched.alu.registers`, as `general_registers.regs[0..7]` and `sp_register.regs`.

## Interface
- No parameters. The optional define `USE_MULTIPLIER` has no effect in this block; the multiplier is not supported.
- `clk` in 1: the single clock. All state is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: tile select; ignored.
- `ui_in` in 8: read response data.
- `uio_in` in 8: bit 2 is `rx_valid` (a response is present on `ui_in` this cycle); other bits are ignored.
- `uo_out` out 8: request payload (address or write data). Registered.
- `uio_out` out 8: bits [1:0] are the request type (0 idle, 1 read, 2 write-address, 3 write-data); other bits are 0. Registered.
- `uio_oe` out 8: constant 8'h03.

## Operation
- Reset state: PC, SP, r0–r7 and flags are all 0. FIFO is empty. `uo_out`=0, `uio_out`=0. FSM is in FETCH0.
- Instruction format: 2 bytes. B0 = {op[3:0], i, rd[2:0]}. B1 holds the operand: src register in B1[2:0] if i=0, or imm8 if i=1, or the target address.
- ALU ops (`rd = rd op src`):
  - op 0 MOV: no flags.
  - op 1 ADD, op 2 ADC, op 3 SUB, op 4 SBC: set Z S C V. C is carry for add and borrow for subtract.
  - op 5 AND, op 6 OR, op 7 XOR: set Z S; clear C V.
  - op 8 CMP: SUB with no writeback.
  - All arithmetic is 8-bit and wraps.
- op 9 LD: `rd = mem[r(B1)]`.
- op 10 ST: `mem[r(B1)] = rd`.
- op 11 PUSH rd: SP−=1, then `mem[SP] = rd`.
- op 12 POP rd: `rd = mem[SP]`, then SP+=1.
- op 13 CALL B1: push return PC (address of the next instruction), then PC = B1.
- op 14 RET: pop into PC.
- op 15 Jcc: cc = B0[3:0]. If the condition is true, PC = B1.
- Condition codes (bit0 inverts the condition):
  - 0 ALWAYS, 1 NEVER
  - 2/3 Z/NZ, 4/5 S/NS, 6/7 C/NC, 8/9 A/NA, 10/11 V/NV, 12/13 G/NG, 14/15 GE/NGE
  - A = !C&!Z; G = !Z&(S==V); GE = (S==V)
  - Aliases: B=NAE=C; AE=NB=NC; BE=NA; NBE=A; NL=GE; L=NGE; NLE=G; LE=NG.
- Message FIFO:
  - Every read request pushes a tag: 1 = opcode byte, 2 = operand byte, 3 = data.
  - A cycle with `rx_valid`=1 pops the head tag and routes `ui_in` by that tag.
  - `rx_valid` while the FIFO is empty is ignored.
  - Simultaneous push and pop are both performed.
  - A read is never issued while the FIFO is full.

## Timing
- FSM states: FETCH0, FETCH1, WAIT, EXEC, MEM, WDATA.
- FETCH0: issue read of PC (tag 1).
- FETCH1: issue read of PC+1 (tag 2); PC+=2 (wraps at 8'hFF).
- WAIT: hold until both bytes have arrived. Responses may arrive from the cycle after the request onward, in order.
- EXEC (1 cycle):
  - ALU, Jcc: write back, then go to FETCH0.
  - LD, POP, RET: issue a tag-3 read, then go to MEM. MEM waits for the response and writes back (POP and RET also do SP+=1).
  - ST, PUSH, CALL: issue write-address (PUSH and CALL predecrement SP), then go to WDATA. WDATA issues write-data for one cycle, then goes to FETCH0.
- Each request occupies exactly one cycle on `uo_out`/`uio_out`. Pins return to 0 on the next cycle unless another request follows.
- Reset asserted mid-instruction aborts it immediately, flushes the FIFO and clears all pins.

## Test plan
- Reset, then supply bytes 08 05 (MOV r0,#5) -> reads at addresses 00 and 01 on consecutive cycles; r0=05; the next read is at 02.
- MOV r0,#5 then ADD r0,#FB (18 FB) -> r0=00, Z=1, C=1, S=0, V=0.
- After the ADD above, execute F2 20 (JZ 20) -> the next opcode read is at address 20. Execute F3 20 (JNZ) instead -> not taken; the next read is at PC+2.
- r1=AA, r2=40, execute A1 02 (ST r1,[r2]) -> one cycle type 2 with `uo_out`=40, then one cycle type 3 with `uo_out`=AA.
- PUSH r3 (B3 00) from SP=00 -> write-address FF and SP=FF. POP r4 (C4 00) with the response 5A -> r4=5A and SP=00.
- CMP r0=01 with #02 -> C=1, S=1, Z=0. Check each cc in turn: B, L, NA taken; A, GE, G not taken. Also: `rx_valid` with an empty FIFO causes no state change.
